// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// hazard_stall_ctrl: load-use bubble, branch flush and data-memory wait sequencing for the 5-stage core.
// Revision: 1.0

module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic             id_rn_used,
  input  logic [3:0]       id_rm,
  input  logic             id_rm_used,
  input  logic [3:0]       id_rd_src,
  input  logic             id_rd_src_used,
  input  logic [3:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_rf_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             perf_clr,
  output logic             nop_sel,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             idex_le,
  output logic             exmem_le,
  output logic             ifid_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic             state_o
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lu;
  logic       mw;
  logic       timeout;
  logic       hold_all;

  always_comb begin
    lu = ex_load & ex_rf_en &
         ((id_rn_used     & (id_rn     == ex_rd)) |
          (id_rm_used     & (id_rm     == ex_rd)) |
          (id_rd_src_used & (id_rd_src == ex_rd)));
    mw      = mem_req & ~mem_ready;
    timeout = (state == MEM_WAIT) & ~mem_ready & (wait_cnt == 8'(MEM_TIMEOUT));
    // In MEM_WAIT the pipeline stays frozen until ready or timeout releases it.
    hold_all = (state == RUN) ? mw : ~(mem_ready | timeout);
  end

  always_comb begin
    nop_sel    = 1'b0;
    pc_le      = 1'b1;
    ifid_le    = 1'b1;
    idex_le    = 1'b1;
    exmem_le   = 1'b1;
    ifid_flush = 1'b0;
    if (reset) begin
      nop_sel  = 1'b1;
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      idex_le  = 1'b0;
      exmem_le = 1'b0;
    end else if (hold_all) begin
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      idex_le  = 1'b0;
      exmem_le = 1'b0;
    end else if (lu) begin
      nop_sel = 1'b1;
      pc_le   = 1'b0;
      ifid_le = 1'b0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      if (perf_clr)
        stall_count <= '0;
      else if (!pc_le && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);

      case (state)
        RUN: begin
          if (mw) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (timeout) begin
            mem_err  <= 1'b1;
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign state_o = (state == MEM_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// tb_hazard_stall_ctrl: directed and random checks of two configurations against a cycle model.
// Revision: 1.0

module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_rn_used, id_rm_used, id_rd_src_used, ex_load, ex_rf_en;
  logic       mem_req, mem_ready, branch_taken, perf_clr;
  logic [3:0] id_rn, id_rm, id_rd_src, ex_rd;

  logic        nop_a, pc_a, ifid_a, idex_a, exmem_a, flush_a, err_a, st_a;
  logic        nop_b, pc_b, ifid_b, idex_b, exmem_b, flush_b, err_b, st_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  hazard_stall_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rn_used(id_rn_used),
    .id_rm(id_rm), .id_rm_used(id_rm_used), .id_rd_src(id_rd_src),
    .id_rd_src_used(id_rd_src_used), .ex_rd(ex_rd), .ex_load(ex_load),
    .ex_rf_en(ex_rf_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .perf_clr(perf_clr), .nop_sel(nop_a),
    .pc_le(pc_a), .ifid_le(ifid_a), .idex_le(idex_a), .exmem_le(exmem_a),
    .ifid_flush(flush_a), .mem_err(err_a), .stall_count(stall_a), .state_o(st_a));

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rn_used(id_rn_used),
    .id_rm(id_rm), .id_rm_used(id_rm_used), .id_rd_src(id_rd_src),
    .id_rd_src_used(id_rd_src_used), .ex_rd(ex_rd), .ex_load(ex_load),
    .ex_rf_en(ex_rf_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .perf_clr(perf_clr), .nop_sel(nop_b),
    .pc_le(pc_b), .ifid_le(ifid_b), .idex_le(idex_b), .exmem_le(exmem_b),
    .ifid_flush(flush_b), .mem_err(err_b), .stall_count(stall_b), .state_o(st_b));

  logic [7:0]  obs [2];
  logic [15:0] cnt_obs [2];
  assign obs[0]     = {nop_a, pc_a, ifid_a, idex_a, exmem_a, flush_a, err_a, st_a};
  assign obs[1]     = {nop_b, pc_b, ifid_b, idex_b, exmem_b, flush_b, err_b, st_b};
  assign cnt_obs[0] = stall_a;
  assign cnt_obs[1] = {12'd0, stall_b};

  // Reference model: per-configuration waiting flag, cycles waited, sticky error, stall total.
  int TO   [2] = '{15, 4};
  int MAXC [2] = '{65535, 15};
  bit m_wait [2];
  int m_wc   [2];
  bit m_err  [2];
  int m_stall[2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic bit hazard();
    bit h = 0;
    if (id_rn_used     && id_rn     == ex_rd) h = 1;
    if (id_rm_used     && id_rm     == ex_rd) h = 1;
    if (id_rd_src_used && id_rd_src == ex_rd) h = 1;
    return h && ex_load && ex_rf_en;
  endfunction

  // {nop_sel, pc_le, ifid_le, idex_le, exmem_le, ifid_flush}
  function automatic logic [5:0] model_ctl(int k);
    bit frozen;
    if (reset) return 6'b100000;
    if (m_wait[k]) frozen = !(mem_ready || m_wc[k] == TO[k]);
    else           frozen = mem_req && !mem_ready;
    if (frozen)       return 6'b000000;
    if (hazard())     return 6'b100110;
    if (branch_taken) return 6'b011111;
    return 6'b011110;
  endfunction

  task automatic cycle(input bit do_chk);
    logic [5:0] ctl [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      ctl[k] = model_ctl(k);
      if (do_chk) begin
        chk($sformatf("outputs[%0d]", k), {24'd0, obs[k]}, {24'd0, ctl[k], m_err[k], m_wait[k]});
        chk($sformatf("stall_count[%0d]", k), {16'd0, cnt_obs[k]}, m_stall[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_wait[k] = 0; m_wc[k] = 0; m_err[k] = 0; m_stall[k] = 0;
      end else begin
        if (perf_clr) m_stall[k] = 0;
        else if (!ctl[k][4] && m_stall[k] < MAXC[k]) m_stall[k]++;
        if (!m_wait[k]) begin
          if (mem_req && !mem_ready) begin m_wait[k] = 1; m_wc[k] = 1; end
        end else if (mem_ready) begin
          m_wait[k] = 0; m_wc[k] = 0;
        end else if (m_wc[k] == TO[k]) begin
          m_err[k] = 1; m_wait[k] = 0; m_wc[k] = 0;
        end else begin
          m_wc[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; id_rn = 0; id_rn_used = 0; id_rm = 0; id_rm_used = 0;
    id_rd_src = 0; id_rd_src_used = 0; ex_rd = 0; ex_load = 0; ex_rf_en = 0;
    mem_req = 0; mem_ready = 0; branch_taken = 0; perf_clr = 0;
  endtask

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    idle();
    reset = 1;
    cycle(0);
    cycle(1);
    chk("reset_nop_sel", {31'd0, nop_a}, 1);
    reset = 0;
    cycle(1);
    chk("post_reset_cnt", {16'd0, stall_a}, 0);
    chk("post_reset_state", {31'd0, st_a}, 0);

    // Load-use on Rm, then the hazard goes away.
    ex_load = 1; ex_rf_en = 1; ex_rd = 3; id_rm = 3; id_rm_used = 1;
    cycle(1);
    ex_load = 0;
    cycle(1);
    chk("lu_stall_cnt", {16'd0, stall_a}, 1);

    // Matching store source register that is not actually read.
    idle(); ex_load = 1; ex_rf_en = 1; ex_rd = 3; id_rd_src = 3;
    cycle(1);
    chk("unused_src_cnt", {16'd0, stall_a}, 1);

    idle(); branch_taken = 1;
    cycle(1);
    ex_load = 1; ex_rf_en = 1; ex_rd = 15; id_rn = 15; id_rn_used = 1;
    cycle(1);
    chk("branch_lu_cnt", {16'd0, stall_a}, 2);

    // Three miss cycles, then ready.
    idle(); perf_clr = 1;
    cycle(1);
    idle(); mem_req = 1;
    repeat (3) cycle(1);
    chk("mem_wait_state", {31'd0, st_a}, 1);
    mem_ready = 1;
    cycle(1);
    chk("mem_wait_cnt", {16'd0, stall_a}, 3);
    chk("mem_wait_state_rel", {31'd0, st_a}, 0);
    chk("mem_wait_err", {30'd0, err_a, err_b}, 0);

    // Timeout on the short-timeout configuration.
    idle(); perf_clr = 1;
    cycle(1);
    idle(); mem_req = 1;
    repeat (5) cycle(1);
    chk("timeout_err_b", {31'd0, err_b}, 1);
    chk("timeout_state_b", {31'd0, st_b}, 0);
    chk("timeout_err_a", {31'd0, err_a}, 0);
    mem_req = 0; mem_ready = 1;
    cycle(1);
    idle();
    repeat (3) cycle(1);
    chk("err_sticky_b", {31'd0, err_b}, 1);

    // Reset in the middle of a wait.
    mem_req = 1;
    repeat (2) cycle(1);
    reset = 1;
    cycle(1);
    chk("mid_wait_reset_state", {30'd0, st_a, st_b}, 0);
    chk("mid_wait_reset_err", {30'd0, err_a, err_b}, 0);
    idle();
    cycle(1);

    // Saturate the 4-bit counter, then clear while still stalling.
    ex_load = 1; ex_rf_en = 1; ex_rd = 2; id_rm = 2; id_rm_used = 1;
    repeat (20) cycle(1);
    chk("saturate_b", {28'd0, stall_b}, 15);
    perf_clr = 1;
    cycle(1);
    chk("clr_over_inc_b", {28'd0, stall_b}, 0);

    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      perf_clr       = ($urandom_range(0, 31) == 0);
      id_rn = rreg(); id_rm = rreg(); id_rd_src = rreg(); ex_rd = rreg();
      id_rn_used     = 1'($urandom);
      id_rm_used     = 1'($urandom);
      id_rd_src_used = 1'($urandom);
      ex_load        = 1'($urandom);
      ex_rf_en       = 1'($urandom);
      mem_req        = ($urandom_range(0, 2) == 0);
      mem_ready      = ($urandom_range(0, 9) < (i < 200 ? 7 : 1));
      branch_taken   = 1'($urandom);
      cycle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
